inst_mem_loader: RTL and testbench

- Write-side companion to the S-Machine instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instructions.
- Issues single-cycle writes into the instruction memory array, then verifies a trailing XOR checksum.
- Holds the CPU (cpu_hold) while a program is being loaded.

---
 rtl/s_machine_pkg.sv | 28 ++
 rtl/inst_mem_loader.sv | 167 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s_machine_pkg.sv
// Shared types and constants for the S-Machine instruction memory loader.
package s_machine_pkg;

    localparam int INST_W     = 16;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W_DEF = 8;

    // Loader sequencing: IDLE -> (HI -> LO -> WRITE)* -> CHECK -> DONE -> IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } ld_state_e;

    // States in which the loader pulls a byte from the stream
    function automatic logic state_accepts(input ld_state_e s);
        logic acc;
        case (s)
            ST_HI, ST_LO, ST_CHECK: acc = 1'b1;
            default:                acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Byte-stream loader: packs byte pairs into 16-bit instructions, writes them
// to instruction memory and verifies a trailing XOR checksum byte.
module inst_mem_loader
    import s_machine_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        hi_d      = hi_q;
        csum_d    = csum_q;
        err_d     = err_q;
        wr_data_d = wr_data_q;
        xfer_s    = in_valid & in_ready_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort beats everything; words already written are left in place
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        count_d = word_count;
                        addr_d  = BASE_ADDR;
                        csum_d  = {BYTE_W{1'b0}};
                        err_d   = 1'b0;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HI: begin
                    if (xfer_s) begin
                        hi_d    = in_data;
                        csum_d  = csum_q ^ in_data;
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_HI;
                    end
                end
                ST_LO: begin
                    if (xfer_s) begin
                        csum_d    = csum_q ^ in_data;
                        wr_data_d = {hi_q, in_data};
                        state_d   = ST_WRITE;
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_WRITE: begin
                    if (count_q == ADDR_ZERO) begin
                        state_d = ST_CHECK;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        count_d = count_q - ADDR_ONE;
                        state_d = ST_HI;
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        err_d   = (in_data != csum_q);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they come out of flops
        in_ready_d = state_accepts(state_d);
        wr_en_d    = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        if (wr_en_d) begin
            wr_addr_d = addr_d;
        end else begin
            wr_addr_d = wr_addr_q;
        end
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= ADDR_ZERO;
            count_q    <= ADDR_ZERO;
            hi_q       <= {BYTE_W{1'b0}};
            csum_q     <= {BYTE_W{1'b0}};
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= ADDR_ZERO;
            wr_data_q  <= {INST_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            hi_q       <= hi_d;
            csum_q     <= csum_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: table of load vectors plus hand-written
// abort, ignored-start and reset-mid-load sequences.
module tb_inst_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        abort;
    logic [7:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        a_in_ready, a_wr_en, a_busy, a_cpu_hold, a_done, a_err;
    logic [7:0]  a_wr_addr;
    logic [15:0] a_wr_data;
    logic        b_in_ready, b_wr_en, b_busy, b_cpu_hold, b_done, b_err;
    logic [7:0]  b_wr_addr;
    logic [15:0] b_wr_data;

    logic        sel;
    logic        m_in_ready, m_wr_en, m_busy, m_cpu_hold, m_done, m_err;
    logic [7:0]  m_wr_addr;
    logic [15:0] m_wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    inst_mem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .busy(a_busy), .cpu_hold(a_cpu_hold),
        .done(a_done), .err(a_err)
    );

    inst_mem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .busy(b_busy), .cpu_hold(b_cpu_hold),
        .done(b_done), .err(b_err)
    );

    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_wr_en    = sel ? b_wr_en    : a_wr_en;
    assign m_wr_addr  = sel ? b_wr_addr  : a_wr_addr;
    assign m_wr_data  = sel ? b_wr_data  : a_wr_data;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_cpu_hold = sel ? b_cpu_hold : a_cpu_hold;
    assign m_done     = sel ? b_done     : a_done;
    assign m_err      = sel ? b_err      : a_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             sel;
        logic [7:0]       wc;
        int               nb;
        logic [0:7][7:0]  b;
        int               gap;
        int               nw;
        logic [0:3][7:0]  ea;
        logic [0:3][15:0] ed;
        logic             eerr;
        int               espace;
    } vec_t;

    vec_t vecs [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   idx, gapcnt, nw, done_cnt, last_w;
        logic pending, fin;
        v = vecs[i];
        sel = v.sel;
        @(negedge clk);
        word_count = v.wc;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk($sformatf("v%0d_busy_after_start", i), {31'd0, m_busy}, 32'd1);
        chk($sformatf("v%0d_hold_after_start", i), {31'd0, m_cpu_hold}, 32'd1);
        chk($sformatf("v%0d_err_cleared", i), {31'd0, m_err}, 32'd0);
        idx = 0; gapcnt = v.gap; nw = 0; done_cnt = 0; last_w = 0;
        pending = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (pending) begin
                idx++;
                gapcnt = v.gap;
            end
            if (m_wr_en) begin
                if (nw < 4) begin
                    chk($sformatf("v%0d_w%0d_addr", i, nw), {24'd0, m_wr_addr}, {24'd0, v.ea[nw]});
                    chk($sformatf("v%0d_w%0d_data", i, nw), {16'd0, m_wr_data}, {16'd0, v.ed[nw]});
                end
                if (nw > 0) chk($sformatf("v%0d_w%0d_spacing", i, nw), cyc - last_w, v.espace);
                last_w = cyc;
                nw++;
            end
            if (m_done) begin
                done_cnt++;
                chk($sformatf("v%0d_busy_at_done", i), {31'd0, m_busy}, 32'd1);
            end else if (done_cnt > 0) begin
                chk($sformatf("v%0d_busy_after_done", i), {31'd0, m_busy}, 32'd0);
                chk($sformatf("v%0d_hold_after_done", i), {31'd0, m_cpu_hold}, 32'd0);
                fin = 1'b1;
            end
            if (idx < v.nb && m_in_ready) begin
                if (gapcnt > 0) begin
                    in_valid = 1'b0;
                    gapcnt--;
                end else begin
                    in_valid = 1'b1;
                    in_data  = v.b[idx];
                end
            end else begin
                in_valid = 1'b0;
            end
            pending = in_valid && m_in_ready;
            if (!fin) @(negedge clk);
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d_finished", i), {31'd0, fin}, 32'd1);
        chk($sformatf("v%0d_write_count", i), nw, v.nw);
        chk($sformatf("v%0d_done_count", i), done_cnt, 32'd1);
        chk($sformatf("v%0d_err", i), {31'd0, m_err}, {31'd0, v.eerr});
    endtask

    initial begin
        int extra_w;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        word_count = 8'd0; in_valid = 1'b0; in_data = 8'd0; sel = 1'b0;

        vecs[0] = '{1'b0, 8'd1, 5, {8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00}, 0, 2,
                    {8'h00, 8'h01, 8'h00, 8'h00}, {16'h1234, 16'hABCD, 16'h0000, 16'h0000}, 1'b0, 3};
        vecs[1] = '{1'b0, 8'd1, 5, {8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00}, 0, 2,
                    {8'h00, 8'h01, 8'h00, 8'h00}, {16'h1234, 16'hABCD, 16'h0000, 16'h0000}, 1'b1, 3};
        vecs[2] = '{1'b0, 8'd1, 5, {8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00}, 2, 2,
                    {8'h00, 8'h01, 8'h00, 8'h00}, {16'h1234, 16'hABCD, 16'h0000, 16'h0000}, 1'b0, 7};
        vecs[3] = '{1'b1, 8'd2, 7, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00}, 0, 3,
                    {8'hFE, 8'hFF, 8'h00, 8'h00}, {16'h0102, 16'h0304, 16'h0506, 16'h0000}, 1'b0, 3};
        vecs[4] = '{1'b0, 8'd0, 3, {8'hBE, 8'hEF, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1,
                    {8'h00, 8'h00, 8'h00, 8'h00}, {16'hBEEF, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, a_wr_en}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_hold", {31'd0, a_cpu_hold}, 32'd0);
        chk("rst_done_err", {30'd0, a_done, a_err}, 32'd0);
        chk("rst_wr_addr_data", {8'd0, a_wr_addr, a_wr_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven loads
        for (int i = 0; i < 4; i++) begin
            run_vec(i);
            if (i == 1) begin
                repeat (3) @(negedge clk);
                chk("err_held_in_idle", {31'd0, m_err}, 32'd1);
            end
        end

        // Abort during second HI, with an ignored start pulsed during LO
        sel = 1'b0;
        @(negedge clk);
        word_count = 8'd3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        chk("ab_lo_ready", {31'd0, a_in_ready}, 32'd1);
        in_data = 8'h22; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; in_valid = 1'b0;
        chk("ab_wr_en", {31'd0, a_wr_en}, 32'd1);
        chk("ab_wr_addr", {24'd0, a_wr_addr}, 32'h00);
        chk("ab_wr_data", {16'd0, a_wr_data}, 32'h1122);
        @(negedge clk);
        chk("ab_hi2_ready", {31'd0, a_in_ready}, 32'd1);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("ab_busy", {31'd0, a_busy}, 32'd0);
        chk("ab_hold", {31'd0, a_cpu_hold}, 32'd0);
        chk("ab_no_done_wr", {30'd0, a_done, a_wr_en}, 32'd0);
        chk("ab_ready", {31'd0, a_in_ready}, 32'd0);
        extra_w = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_wr_en || a_done || a_busy) extra_w++;
        end
        chk("ab_quiet_after", extra_w, 32'd0);

        // Start and abort together in IDLE: abort wins
        start_a = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", {31'd0, a_busy}, 32'd0);
        chk("idle_abort_ready", {31'd0, a_in_ready}, 32'd0);

        // Reset asserted during LO of word 1
        @(negedge clk);
        word_count = 8'd1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        in_data = 8'hBB;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rm_first_write", {16'd0, a_wr_data}, 32'hAABB);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rm_in_lo", {31'd0, a_in_ready}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_async_ctrl", {26'd0, a_in_ready, a_wr_en, a_busy, a_cpu_hold, a_done, a_err}, 32'd0);
        chk("rm_async_data", {8'd0, a_wr_addr, a_wr_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
